// File: rtl/spi_master_engine.sv
// SPI master shift engine sitting between a TX FIFO (pop side) and an RX FIFO (push side).
// Optional macro SPI_LOOPBACK_EN adds a loopback input that samples internal mosi instead of miso.
`ifndef SPI_DATA_WIDTH
  `define SPI_DATA_WIDTH 8
`endif

module spi_master_engine #(
  parameter int DATA_WIDTH = `SPI_DATA_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_dout,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_din,
  output logic                  rx_wr_en,
  input  logic                  rx_full,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  cs_n,
  output logic                  busy
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, NEXT, DONE} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  sample_bit;
  logic                  start_load;
  logic                  div_hit;
  logic                  last_edge;
  logic                  sample_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  // A new word may start from IDLE or, for a continuous burst, from NEXT.
  assign start_load  = ((state == IDLE) || (state == NEXT)) && enable && !tx_empty;
  assign div_hit     = (div_cnt == DIV_LAST);
  assign last_edge   = (edge_cnt == EDGE_LAST);
  // Even edge counts are leading edges; CPHA picks which edge type samples.
  assign sample_edge = (edge_cnt[0] == CPHA);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_din   <= '0;
      tx_rd_en <= 1'b0;
      rx_wr_en <= 1'b0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      tx_rd_en <= 1'b0;
      rx_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start_load) state <= LOAD;
        end
        LOAD: begin
          state    <= SHIFT;
          div_cnt  <= '0;
          edge_cnt <= '0;
        end
        SHIFT: begin
          if (div_hit) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (sample_edge) begin
              rx_shift <= shift_in(rx_shift, sample_bit);
            end else if (CPHA) begin
              mosi     <= first_bit(tx_shift);
              tx_shift <= shift_out(tx_shift);
            end else if (!last_edge) begin
              mosi     <= first_bit(shift_out(tx_shift));
              tx_shift <= shift_out(tx_shift);
            end
            if (last_edge) state <= STORE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STORE: begin
          // Backpressure: hold the assembled word until the RX FIFO has room.
          if (!rx_full) begin
            rx_wr_en <= 1'b1;
            rx_din   <= rx_shift;
            state    <= NEXT;
          end
        end
        NEXT: begin
          if (start_load) begin
            state <= LOAD;
          end else begin
            state   <= DONE;
            div_cnt <= '0;
          end
        end
        DONE: begin
          if (div_hit) begin
            cs_n    <= 1'b1;
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Word launch: pop strobe, chip select, and first bit for CPHA=0.
      if (start_load) begin
        tx_rd_en <= 1'b1;
        cs_n     <= 1'b0;
        tx_shift <= tx_dout;
        if (!CPHA) mosi <= first_bit(tx_dout);
      end
    end
  end

endmodule
